// File: rtl/seg7_pkg.sv
// Shared constants and types for capturing a multiplexed seven-segment display back into BCD.
package seg7_pkg;

    // Segment order is led[1:7] = a..g, active-low (0 = lit).
    localparam logic [1:7] SEG_0     = 7'b0000001;
    localparam logic [1:7] SEG_1     = 7'b1001111;
    localparam logic [1:7] SEG_2     = 7'b0010010;
    localparam logic [1:7] SEG_3     = 7'b0000110;
    localparam logic [1:7] SEG_4     = 7'b1001100;
    localparam logic [1:7] SEG_5     = 7'b0100100;
    localparam logic [1:7] SEG_6     = 7'b0100000;
    localparam logic [1:7] SEG_7     = 7'b0001111;
    localparam logic [1:7] SEG_8     = 7'b0000000;
    localparam logic [1:7] SEG_9     = 7'b0000100;
    localparam logic [1:7] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_ERR   = 4'hE;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SAMPLE,
        ST_HOLD
    } dwell_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the BCD-to-seven-segment encoder: active-low segments to BCD plus flags.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [1:7] led,
    output logic [3:0] code,
    output logic       blank,
    output logic       err
);

    always_comb begin
        code  = BCD_ERR;
        blank = 1'b0;
        err   = 1'b1;
        case (led)
            SEG_0:     begin code = 4'd0; err = 1'b0; end
            SEG_1:     begin code = 4'd1; err = 1'b0; end
            SEG_2:     begin code = 4'd2; err = 1'b0; end
            SEG_3:     begin code = 4'd3; err = 1'b0; end
            SEG_4:     begin code = 4'd4; err = 1'b0; end
            SEG_5:     begin code = 4'd5; err = 1'b0; end
            SEG_6:     begin code = 4'd6; err = 1'b0; end
            SEG_7:     begin code = 4'd7; err = 1'b0; end
            SEG_8:     begin code = 4'd8; err = 1'b0; end
            SEG_9:     begin code = 4'd9; err = 1'b0; end
            SEG_BLANK: begin code = BCD_BLANK; blank = 1'b1; err = 1'b0; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Watches a multiplexed active-low display bus, samples each digit once it has settled,
// and publishes a packed BCD frame once every digit has been captured.
module seg7_scan_capture #(
    parameter int DIGITS = 4,
    parameter int SETTLE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:7]            led,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank_out,
    output logic [DIGITS-1:0]     err_out,
    output logic                  frame_valid
);
    import seg7_pkg::*;

    localparam int CW = $clog2(SETTLE + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIGITS-1:0]   an_prev_q, an_prev_d;
    logic [1:7]          led_prev_q, led_prev_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    dwell_state_e        state_q, state_d;
    logic [4*DIGITS-1:0] slot_code_q, slot_code_d;
    logic [DIGITS-1:0]   slot_blank_q, slot_blank_d;
    logic [DIGITS-1:0]   slot_err_q, slot_err_d;
    logic [DIGITS-1:0]   captured_q, captured_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic [DIGITS-1:0]   err_q, err_d;
    logic                frame_valid_q, frame_valid_d;

    logic [DIGITS-1:0]   an_n;
    logic                an_valid;
    logic                stable;
    logic                sample;
    logic                frame_done;
    logic [IW-1:0]       digit_idx;
    logic [3:0]          dec_code;
    logic                dec_blank;
    logic                dec_err;

    seg7_pattern_decode u_decode (
        .led   (led),
        .code  (dec_code),
        .blank (dec_blank),
        .err   (dec_err)
    );

    always_comb begin
        an_n      = ~an;
        an_valid  = (an_n != '0) && ((an_n & (an_n - DIGITS'(1))) == '0);
        stable    = (an == an_prev_q) && (led == led_prev_q);
        digit_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (an_n[i]) digit_idx = digit_idx | IW'(i);
        end
    end

    // The sample fires on the edge the counter steps into SETTLE-1, i.e. the SETTLE-th stable cycle.
    always_comb begin
        an_prev_d  = an;
        led_prev_d = led;
        cnt_d      = cnt_q;
        state_d    = state_q;
        sample     = stable && an_valid && (state_q == ST_WAIT) && (cnt_q == CW'(SETTLE - 2));

        if (!stable || !an_valid) begin
            cnt_d   = '0;
            state_d = ST_WAIT;
        end else begin
            if (cnt_q != CW'(SETTLE)) cnt_d = cnt_q + CW'(1);
            case (state_q)
                ST_WAIT:   if (sample) state_d = ST_SAMPLE;
                ST_SAMPLE: state_d = ST_HOLD;
                ST_HOLD:   state_d = ST_HOLD;
                default:   state_d = ST_WAIT;
            endcase
        end
    end

    // A sample landing on the publish edge seeds the next frame, so its bit wins over the clear.
    always_comb begin
        frame_done    = &captured_q;
        slot_code_d   = slot_code_q;
        slot_blank_d  = slot_blank_q;
        slot_err_d    = slot_err_q;
        captured_d    = frame_done ? '0 : captured_q;
        bcd_d         = frame_done ? slot_code_q : bcd_q;
        blank_d       = frame_done ? slot_blank_q : blank_q;
        err_d         = frame_done ? slot_err_q : err_q;
        frame_valid_d = frame_done;

        if (sample) begin
            slot_code_d[4*digit_idx +: 4] = dec_code;
            slot_blank_d[digit_idx]       = dec_blank;
            slot_err_d[digit_idx]         = dec_err;
            captured_d[digit_idx]         = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_prev_q     <= '1;
            led_prev_q    <= '1;
            cnt_q         <= '0;
            state_q       <= ST_WAIT;
            slot_code_q   <= '1;
            slot_blank_q  <= '1;
            slot_err_q    <= '0;
            captured_q    <= '0;
            bcd_q         <= '1;
            blank_q       <= '1;
            err_q         <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            an_prev_q     <= an_prev_d;
            led_prev_q    <= led_prev_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            slot_code_q   <= slot_code_d;
            slot_blank_q  <= slot_blank_d;
            slot_err_q    <= slot_err_d;
            captured_q    <= captured_d;
            bcd_q         <= bcd_d;
            blank_q       <= blank_d;
            err_q         <= err_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign blank_out   = blank_q;
    assign err_out     = err_q;
    assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: directed scans plus a random dwell sequence checked
// against a run-length model of the display bus.
module tb_seg7_scan_capture;

    localparam int DIGITS = 4;
    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:7]  led;
    logic [3:0]  an;
    logic [15:0] bcd_out;
    logic [3:0]  blank_out;
    logic [3:0]  err_out;
    logic        frame_valid;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [23:0] got_q[$];
    int          got_cyc[$];
    logic [23:0] exp_q[$];

    logic [15:0] m_bcd;
    logic [3:0]  m_blank;
    logic [3:0]  m_err;
    logic [3:0]  m_cap;
    logic [3:0]  run_an;
    logic [1:7]  run_led;
    int          run_len;

    seg7_scan_capture #(.DIGITS(DIGITS), .SETTLE(SETTLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .led         (led),
        .an          (an),
        .bcd_out     (bcd_out),
        .blank_out   (blank_out),
        .err_out     (err_out),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            got_q.push_back({bcd_out, blank_out, err_out});
            got_cyc.push_back(cyc);
        end
    end

    function automatic logic [5:0] ref_decode(input logic [1:7] p);
        logic [6:0] tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        for (int k = 0; k < 10; k++) begin
            if (p == tab[k]) return {4'(k), 2'b00};
        end
        if (p == 7'b1111111) return {4'hF, 2'b10};
        return {4'hE, 2'b01};
    endfunction

    function automatic int ref_digit(input logic [3:0] a);
        logic [3:0] m;
        for (int k = 0; k < DIGITS; k++) begin
            m = 4'b1111;
            m[k] = 1'b0;
            if (a == m) return k;
        end
        return -1;
    endfunction

    function automatic logic [1:7] seg_of(input int v);
        logic [6:0] tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        return tab[v];
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one dwell; a digit is captured once its run of identical values reaches SETTLE cycles.
    task automatic apply_stimulus(input logic [3:0] a, input logic [1:7] l, input int n);
        int old_len;
        int d;
        logic [5:0] dec;
        an  = a;
        led = l;
        if (a == run_an && l == run_led) begin
            old_len = run_len;
            run_len = run_len + n;
        end else begin
            old_len = 0;
            run_an  = a;
            run_led = l;
            run_len = n;
        end
        d = ref_digit(a);
        if (d >= 0 && old_len < SETTLE && run_len >= SETTLE) begin
            dec = ref_decode(l);
            m_bcd[4*d +: 4] = dec[5:2];
            m_blank[d]      = dec[1];
            m_err[d]        = dec[0];
            m_cap[d]        = 1'b1;
            if (m_cap == 4'hF) begin
                exp_q.push_back({m_bcd, m_blank, m_err});
                m_cap = 4'h0;
            end
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            an  = 4'($urandom);
            led = 7'($urandom);
            @(negedge clk);
        end
        check_output("reset_bcd", 32'(bcd_out), 32'hFFFF);
        check_output("reset_blank", 32'(blank_out), 32'hF);
        check_output("reset_err", 32'(err_out), 32'h0);
        check_output("reset_fv", 32'(frame_valid), 32'h0);
        rst     = 1'b0;
        an      = 4'hF;
        led     = 7'h7F;
        m_cap   = 4'h0;
        run_an  = 4'hF;
        run_led = 7'h7F;
        run_len = 0;
    endtask

    task automatic check_single_frame(input string tag, input logic [23:0] frame_exp);
        check_output({tag, "_count"}, 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check_output({tag, "_frame"}, 32'(got_q[0]), 32'(frame_exp));
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        int start;
        int n_cmp;
        logic [3:0] ra;
        logic [1:7] rl;

        rst = 1'b1;
        an  = 4'hF;
        led = 7'h7F;
        @(negedge clk);

        $display("[TB] reset behaviour");
        do_reset(3);
        check_output("reset_no_frames", 32'(got_q.size()), 32'd0);

        $display("[TB] normal scan");
        apply_stimulus(4'b1110, seg_of(1), 6);
        apply_stimulus(4'b1101, seg_of(2), 6);
        apply_stimulus(4'b1011, seg_of(3), 6);
        apply_stimulus(4'b0111, seg_of(4), 6);
        apply_stimulus(4'b1111, 7'h7F, 4);
        check_single_frame("normal", {16'h4321, 4'h0, 4'h0});

        $display("[TB] minimum-period scan and latency");
        start = cyc;
        apply_stimulus(4'b1110, seg_of(5), SETTLE);
        apply_stimulus(4'b1101, seg_of(6), SETTLE);
        apply_stimulus(4'b1011, seg_of(7), SETTLE);
        apply_stimulus(4'b0111, seg_of(8), SETTLE);
        apply_stimulus(4'b1111, 7'h7F, 4);
        if (got_cyc.size() > 0) check_output("minperiod_latency", 32'(got_cyc[0]), 32'(start + DIGITS*SETTLE + 1));
        check_single_frame("minperiod", {16'h8765, 4'h0, 4'h0});

        $display("[TB] glitch rejection");
        apply_stimulus(4'b1110, seg_of(0), 3);
        apply_stimulus(4'b1110, seg_of(1), 6);
        apply_stimulus(4'b1101, seg_of(0), 6);
        apply_stimulus(4'b1011, seg_of(0), 6);
        apply_stimulus(4'b0111, seg_of(0), 6);
        apply_stimulus(4'b1111, 7'h7F, 4);
        check_single_frame("glitch", {16'h0001, 4'h0, 4'h0});

        $display("[TB] blank and invalid patterns");
        apply_stimulus(4'b1110, seg_of(7), 6);
        apply_stimulus(4'b1101, seg_of(7), 6);
        apply_stimulus(4'b1011, 7'b1111111, 6);
        apply_stimulus(4'b0111, 7'b1010101, 6);
        apply_stimulus(4'b1111, 7'h7F, 4);
        check_single_frame("blank_err", {16'hEF77, 4'b0100, 4'b1000});

        $display("[TB] invalid select");
        apply_stimulus(4'b1111, seg_of(3), 20);
        apply_stimulus(4'b1100, seg_of(3), 20);
        check_output("invalid_no_frames", 32'(got_q.size()), 32'd0);
        check_output("invalid_hold_bcd", 32'(bcd_out), 32'hEF77);
        apply_stimulus(4'b1110, seg_of(9), 6);
        apply_stimulus(4'b1101, seg_of(8), 6);
        apply_stimulus(4'b1011, seg_of(7), 6);
        apply_stimulus(4'b0111, seg_of(6), 6);
        apply_stimulus(4'b1111, 7'h7F, 4);
        check_single_frame("after_invalid", {16'h6789, 4'h0, 4'h0});

        $display("[TB] mid-frame reset and overwrite");
        apply_stimulus(4'b1110, seg_of(3), 6);
        apply_stimulus(4'b1101, seg_of(2), 6);
        do_reset(2);
        check_output("midreset_no_frames", 32'(got_q.size()), 32'd0);
        apply_stimulus(4'b1110, seg_of(1), 6);
        apply_stimulus(4'b1101, seg_of(5), 6);
        apply_stimulus(4'b1101, seg_of(9), 6);
        apply_stimulus(4'b1011, seg_of(2), 6);
        apply_stimulus(4'b0111, seg_of(3), 6);
        apply_stimulus(4'b1111, 7'h7F, 4);
        check_single_frame("overwrite", {16'h3291, 4'h0, 4'h0});

        $display("[TB] random dwells");
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 5) == 0) ra = 4'($urandom);
            else begin
                ra = 4'b1111;
                ra[$urandom_range(0, DIGITS-1)] = 1'b0;
            end
            case ($urandom_range(0, 7))
                0:       rl = 7'b1111111;
                1:       rl = 7'($urandom);
                default: rl = seg_of($urandom_range(0, 9));
            endcase
            apply_stimulus(ra, rl, $urandom_range(1, 2*SETTLE));
        end
        apply_stimulus(4'b1111, 7'h7F, 4);
        check_output("random_count", 32'(got_q.size()), 32'(exp_q.size()));
        n_cmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++) begin
            check_output($sformatf("random_frame%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
